// File: rtl/fu_wb_arbiter_if.sv
// Bundle between the functional units, the writeback arbiter and the scoreboard.
// master = producer/consumer side (FUs + scoreboard), slave = arbiter.
interface fu_wb_arbiter_if #(
  parameter int NrChannels    = 4,
  parameter int NrWbPorts     = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
);
  logic [NrChannels-1:0]                    valid_i;
  logic [NrChannels-1:0]                    ready_o;
  logic [NrChannels-1:0][XLEN-1:0]          result_i;
  logic [NrChannels-1:0][TRANS_ID_BITS-1:0] trans_id_i;
  logic [NrChannels-1:0]                    ex_valid_i;
  logic [NrChannels-1:0][XLEN-1:0]          ex_cause_i;
  logic [NrWbPorts-1:0]                     wb_valid_o;
  logic [NrWbPorts-1:0][XLEN-1:0]           wb_result_o;
  logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o;
  logic [NrWbPorts-1:0]                     wb_ex_valid_o;
  logic [NrWbPorts-1:0][XLEN-1:0]           wb_ex_cause_o;

  modport master (
    output valid_i, result_i, trans_id_i, ex_valid_i, ex_cause_i,
    input  ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o
  );
  modport slave (
    input  valid_i, result_i, trans_id_i, ex_valid_i, ex_cause_i,
    output ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin onto NrWbPorts ports.
// Optional same-cycle bypass of empty FIFOs: define ARIANE_WB_ARB_BYPASS_EN.
module fu_wb_fifo #(
  parameter int Depth = 2,
  parameter int W     = 8
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ready
);
  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);

  logic [Depth-1:0][W-1:0] mem;
  logic [PW-1:0]           rptr, wptr;
  logic [CW-1:0]           cnt;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge gclk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
  assign ready = (cnt < CW'(Depth));
endmodule

module fu_wb_arbiter #(
  parameter int NrChannels    = 4,
  parameter int NrWbPorts     = 2,
  parameter int Depth         = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  fu_wb_arbiter_if.slave  bus
);
  localparam int CHW = $clog2(NrChannels);

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_cause;
  } entry_t;

  entry_t [NrChannels-1:0] in_e, head_e, src_e;
  logic   [NrChannels-1:0] empty, rdy, avail, grant, push, pop;
  logic   [CHW-1:0]        rr_q, rr_d;

  logic [NrWbPorts-1:0][CHW-1:0] port_ch;
  logic [NrWbPorts-1:0]          port_vld;
  int                            n_g, last_g, idx;

  for (genvar c = 0; c < NrChannels; c++) begin : g_ch
    assign in_e[c] = '{result:   bus.result_i[c],   trans_id: bus.trans_id_i[c],
                       ex_valid: bus.ex_valid_i[c], ex_cause: bus.ex_cause_i[c]};
    // A bypassed entry (granted while its FIFO is empty) is never stored.
    assign pop[c]  = grant[c] & ~empty[c];
    assign push[c] = bus.valid_i[c] & rdy[c] & ~flush_i & ~(grant[c] & empty[c]);

    fu_wb_fifo #(.Depth(Depth), .W($bits(entry_t))) u_fifo (
      .gclk  (clk_i),
      .grst_n(rst_ni),
      .flush (flush_i),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (in_e[c]),
      .dout  (head_e[c]),
      .empty (empty[c]),
      .ready (rdy[c])
    );

`ifdef ARIANE_WB_ARB_BYPASS_EN
    assign avail[c] = ~empty[c] | bus.valid_i[c];
    assign src_e[c] = empty[c] ? in_e[c] : head_e[c];
`else
    assign avail[c] = ~empty[c];
    assign src_e[c] = head_e[c];
`endif
  end

  assign bus.ready_o = rdy;

  // Scan from rr_q, handing ports out in order to the first non-empty channels.
  always_comb begin
    grant    = '0;
    port_ch  = '0;
    port_vld = '0;
    n_g      = 0;
    last_g   = 0;
    idx      = 0;
    if (rst_ni && !flush_i) begin
      for (int p = 0; p < NrChannels; p++) begin
        idx = int'(rr_q) + p;
        if (idx >= NrChannels) idx = idx - NrChannels;
        if (avail[idx] && n_g < NrWbPorts) begin
          grant[idx]    = 1'b1;
          port_ch[n_g]  = CHW'(idx);
          port_vld[n_g] = 1'b1;
          last_g        = idx;
          n_g           = n_g + 1;
        end
      end
    end
    rr_d = (last_g + 1 >= NrChannels) ? '0 : CHW'(last_g + 1);
  end

  always_comb begin
    bus.wb_valid_o    = '0;
    bus.wb_result_o   = '0;
    bus.wb_trans_id_o = '0;
    bus.wb_ex_valid_o = '0;
    bus.wb_ex_cause_o = '0;
    for (int k = 0; k < NrWbPorts; k++) begin
      if (port_vld[k]) begin
        bus.wb_valid_o[k]    = 1'b1;
        bus.wb_result_o[k]   = src_e[port_ch[k]].result;
        bus.wb_trans_id_o[k] = src_e[port_ch[k]].trans_id;
        bus.wb_ex_valid_o[k] = src_e[port_ch[k]].ex_valid;
        bus.wb_ex_cause_o[k] = src_e[port_ch[k]].ex_cause;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       rr_q <= '0;
    else if (flush_i)  rr_q <= '0;
    else if (|grant)   rr_q <= rr_d;
  end

  // Producers must hold off while ready_o is low; such a push is dropped.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.valid_i & ~rdy) == '0);
endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Parametrised writeback arbiter that collects results from NrChannels functional units (ALU/branch, CSR, multiplier, FPU, ...) into per-channel result FIFOs and drains them round-robin onto NrWbPorts scoreboard writeback ports.
- Sits between the execute-stage functional units and the scoreboard.
- Replaces the fixed-priority single-port result mux, so multi-cycle units no longer rely on issue-side collision avoidance.

## Interface
Parameters:
- NrChannels, 4, number of producing functional units (2..8)
- NrWbPorts, 2, number of scoreboard writeback ports (1..NrChannels)
- Depth, 2, entries per channel FIFO (power of two, ≥2)
- XLEN, 64, result width
- TRANS_ID_BITS, from ariane_pkg, scoreboard transaction id width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all buffered results
- valid_i  in  [NrChannels]  channel result valid
- ready_o  out  [NrChannels]  channel FIFO can accept
- result_i  in  [NrChannels][XLEN]  result data
- trans_id_i  in  [NrChannels][TRANS_ID_BITS]  scoreboard id
- ex_valid_i  in  [NrChannels]  exception flag
- ex_cause_i  in  [NrChannels][XLEN]  exception cause
- wb_valid_o  out  [NrWbPorts]  writeback valid (no backpressure; scoreboard always accepts)
- wb_result_o  out  [NrWbPorts][XLEN]  writeback data
- wb_trans_id_o  out  [NrWbPorts][TRANS_ID_BITS]  writeback id
- wb_ex_valid_o  out  [NrWbPorts]  exception flag
- wb_ex_cause_o  out  [NrWbPorts][XLEN]  exception cause

## Operation
- Per channel: circular FIFO with read pointer, write pointer and count of width $clog2(Depth+1). Pointers wrap modulo Depth.
- Push on valid_i && ready_o.
- valid_i while !ready_o is a protocol violation: the entry is dropped and an assertion fires.
- ready_o = (count < Depth). It is registered-state only, with no combinational dependence on same-cycle pops.
- Arbitration:
  - Round-robin pointer rr_q in [0, NrChannels).
  - Each cycle, scan channels rr_q, rr_q+1, ... (mod NrChannels) and grant the first NrWbPorts non-empty channels, at most one grant per channel per cycle.
  - Grant k drives writeback port k.
  - Ungranted ports output wb_valid_o=0 and all data fields 0.
- rr_q update: if any grant, rr_q ← (index of last granted channel + 1) mod NrChannels; otherwise unchanged.
- A granted channel pops its head in the same cycle.
- Simultaneous push and pop on a full FIFO is legal only if ready_o was 1 at the push, so it cannot occur. Push and pop on a non-full FIFO leave count unchanged.
- Entries within one channel leave in FIFO order. There is no ordering guarantee between channels.
- Flush:
  - In the flush_i cycle all counts and pointers clear and rr_q ← 0.
  - Same-cycle pushes are discarded and wb_valid_o is forced to all-zero.
  - ready_o is 1 on all channels in the next cycle.
- Reset (rst_ni=0, any time, including mid-drain): same state as flush. All outputs are 0 except ready_o, which is all-ones.

## Timing
- Without bypass: a result pushed in cycle N can appear on a writeback port in cycle N+1 at the earliest.
- Writeback outputs are combinational from FIFO heads and rr_q.
- Worst-case wait for a non-empty channel head: ceil(NrChannels/NrWbPorts) − 1 cycles (round-robin fairness).
- Sustained throughput: NrWbPorts results per cycle when ≥NrWbPorts channels are non-empty.

## Configuration
- Macro: ARIANE_WB_ARB_BYPASS_EN.
- Defined:
  - A channel with an empty FIFO and valid_i=1 counts as non-empty for arbitration in the same cycle.
  - If granted, its input goes directly to the writeback port in cycle N and is not written into the FIFO.
  - ready_o is unchanged.
  - Flush still suppresses the bypass.
- Undefined: no bypass path; minimum latency is 1 cycle.

## Test plan
- Reset mid-drain: fill channel 0 with 2 entries, assert rst_ni=0 while one is in flight → all wb_valid_o=0; after release ready_o=4'b1111 and no stale entry is ever written back.
- Round-robin fairness: NrChannels=4, NrWbPorts=2, all four FIFOs holding entries with trans_id=ch → cycle 1 grants {0,1}, cycle 2 grants {2,3}, then rr_q=0.
- Backpressure: push 2 results into channel 2 with no grants possible (other channels hogging) → ready_o[2]=0 after the 2nd push; ready_o[2] returns to 1 the cycle after its first pop.
- Flush with simultaneous push: channel 1 holds 1 entry, channel 3 pushes trans_id=5 in the flush cycle → no writeback of either entry; all counts are 0 next cycle.
- Latency/bypass: single push on idle channel 0 (result=64'hDEAD, trans_id=3) → wb_valid_o[0] in the same cycle with ARIANE_WB_ARB_BYPASS_EN, next cycle without it; exception fields pass through unchanged.
- Wrap-around: stream 10 results through channel 1 at one per cycle with continuous grant → all 10 written back in order; pointers wrap cleanly and no entry is lost or duplicated.
